// File: rtl/mha_pkg.sv
// Shared definitions for the QKV projection sequencer.
// Holds the sequencer state encoding, the default parameter constants and
// a helper that sizes a counter for a given terminal limit.
package mha_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WLOAD     = 3'd1,
        S_ASTREAM   = 3'd2,
        S_PROPAGATE = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int ROWS_DEF      = 4;
    localparam int COLS_DEF      = 16;
    localparam int TOKENS_DEF    = 729;
    localparam int IN_GROUPS_DEF = 16;
    localparam int PIPE_LAT_DEF  = 3;
    localparam int ADDR_W_DEF    = 32;

    // Counter width for a counter running 0..limit-1, never narrower than 1.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/mha_delay_line.sv
// Valid+data shift register that times output-row writes.
// Ports:
//   clk       - clock
//   clr       - synchronous clear of every stage (valid and data)
//   en        - advance the line by one stage; holds when low
//   in_valid  - valid bit entering stage 0
//   in_data   - data entering stage 0
//   out_valid - valid bit leaving the last stage (DEPTH enabled cycles later)
//   out_data  - data leaving the last stage
module mha_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] vld_r;
    logic [W-1:0]     dat_r [DEPTH];

    // Shift stages forward on enable; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_r[i] <= '0;
            end
        end else if (en) begin
            vld_r[0] <= in_valid;
            dat_r[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                dat_r[i] <= dat_r[i-1];
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_data  = dat_r[DEPTH-1];

endmodule

// File: rtl/qkv_proj_seq.sv
// QKV projection sequencer: for each input-channel group loads ROWS weight
// words, streams TOKENS activations, waits COLS-1 cycles for propagation,
// and after the last group drains the MAC pipeline and pulses done.
// Activation reads of the last group are echoed as output-row writes
// PIPE_LAT+COLS enabled cycles later. COLS must be at least 2.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - begins a run when idle
//   stall      - SRAM not ready; freezes all sequencing, blanks strobes
//   is_wt      - current read is a weight load
//   rd_en      - SRAM read strobe;  rd_addr - read address (0 when idle)
//   wr_en      - output-row write;  wr_addr - write address (0 when idle)
//   busy       - run in progress;   done    - one-cycle completion pulse
module qkv_proj_seq
    import mha_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int TOKENS    = TOKENS_DEF,
    parameter int IN_GROUPS = IN_GROUPS_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int W_BASE    = 0,
    parameter int A_BASE    = 0,
    parameter int O_BASE    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              is_wt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam int LAT = PIPE_LAT + COLS;
    localparam int K_W = cnt_width(ROWS);
    localparam int T_W = cnt_width(TOKENS);
    localparam int G_W = cnt_width(IN_GROUPS);
    localparam int D_W = cnt_width(LAT);

    state_t         state_r, state_s;
    logic [G_W-1:0] g_r, g_s;
    logic [K_W-1:0] k_r, k_s;
    logic [T_W-1:0] t_r, t_s;
    logic [D_W-1:0] d_r, d_s;

    logic           last_group_s;
    logic           dly_in_valid_s;
    logic           dly_out_valid_s;
    logic [T_W-1:0] dly_out_data_s;

    assign last_group_s = (g_r == G_W'(IN_GROUPS - 1));

    // State and counter registers; stall freezes them, reset wins over both.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            g_r     <= '0;
            k_r     <= '0;
            t_r     <= '0;
            d_r     <= '0;
        end else if (!stall) begin
            state_r <= state_s;
            g_r     <= g_s;
            k_r     <= k_s;
            t_r     <= t_s;
            d_r     <= d_s;
        end
    end

    // Next-state and counter sequencing; counters clear at terminal count.
    always_comb begin
        state_s = state_r;
        g_s     = g_r;
        k_s     = k_r;
        t_s     = t_r;
        d_s     = d_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_WLOAD;
                    g_s     = '0;
                    k_s     = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WLOAD: begin
                if (k_r == K_W'(ROWS - 1)) begin
                    k_s     = '0;
                    t_s     = '0;
                    state_s = S_ASTREAM;
                end else begin
                    k_s = k_r + K_W'(1);
                end
            end
            S_ASTREAM: begin
                if (t_r == T_W'(TOKENS - 1)) begin
                    t_s     = '0;
                    d_s     = '0;
                    state_s = S_PROPAGATE;
                end else begin
                    t_s = t_r + T_W'(1);
                end
            end
            S_PROPAGATE: begin
                if (d_r == D_W'(COLS - 2)) begin
                    d_s = '0;
                    if (last_group_s) begin
                        g_s     = '0;
                        state_s = S_DRAIN;
                    end else begin
                        g_s     = g_r + G_W'(1);
                        state_s = S_WLOAD;
                    end
                end else begin
                    d_s = d_r + D_W'(1);
                end
            end
            S_DRAIN: begin
                if (d_r == D_W'(LAT - 1)) begin
                    d_s     = '0;
                    state_s = S_DONE;
                end else begin
                    d_s = d_r + D_W'(1);
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Read-side outputs decoded from state; stall blanks the strobes.
    always_comb begin
        is_wt   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        busy    = (state_r != S_IDLE);
        done    = 1'b0;
        case (state_r)
            S_WLOAD: begin
                is_wt = 1'b1;
                if (!stall) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(W_BASE) + ADDR_W'(g_r) * ADDR_W'(ROWS)
                              + ADDR_W'(k_r);
                end else begin
                    rd_en = 1'b0;
                end
            end
            S_ASTREAM: begin
                if (!stall) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(A_BASE) + ADDR_W'(g_r) * ADDR_W'(TOKENS)
                              + ADDR_W'(t_r);
                end else begin
                    rd_en = 1'b0;
                end
            end
            S_DONE: begin
                done = !stall;
            end
            default: begin
                rd_en = 1'b0;
            end
        endcase
    end

    // Only last-group activation reads become output writes.
    assign dly_in_valid_s = (state_r == S_ASTREAM) && last_group_s;

    mha_delay_line #(
        .DEPTH (LAT),
        .W     (T_W)
    ) u_delay (
        .clk       (clk),
        .clr       (reset),
        .en        (!stall),
        .in_valid  (dly_in_valid_s),
        .in_data   (t_r),
        .out_valid (dly_out_valid_s),
        .out_data  (dly_out_data_s)
    );

    // Write-side outputs; address forced to 0 when not writing.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (dly_out_valid_s && !stall) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(O_BASE) + ADDR_W'(dly_out_data_s);
        end else begin
            wr_en = 1'b0;
        end
    end

endmodule
